// File: rtl/ro_demux.sv
// ro_demux -- demultiplexes a time-shared I/Q readout line into per-channel
// event words and queues them in a small FIFO.
//
// A free-running 10-bit slot counter assigns each cycle to a channel equal to
// the number of trailing ones of the counter, so channel k owns one cycle out
// of every 2^(k+1); the all-ones count is an idle slot. Every wrap of the slot
// counter advances an 8-bit frame number. A non-zero readout in an owned slot
// is captured as {channel, Q[1:0], I[1:0], frame} and queued.
//
// Ports
//   clk_master  : single clock, rising edge
//   rst         : synchronous active-high reset
//   read_out_I  : shared I line, [0]=event, [1]=polarity-gated event
//   read_out_Q  : shared Q line, same meaning
//   en          : capture enable (counters keep running when low)
//   sync        : forces slot and frame counters to zero on the next edge
//   out_data    : FIFO head word
//   out_valid   : FIFO non-empty
//   out_ready   : consumer accept; pop when out_valid & out_ready
//   overflow    : sticky, set when a word is dropped
//   clr_ovf     : clears overflow and drop_cnt (wins over a same-cycle drop)
//   drop_cnt    : dropped-word count, saturating at 255
//   slot        : channel of the current cycle, 10 = idle
module ro_demux #(
  parameter int FIFO_DEPTH = 8,
  parameter int NCH        = 10
) (
  input  logic        clk_master,
  input  logic        rst,
  input  logic [1:0]  read_out_I,
  input  logic [1:0]  read_out_Q,
  input  logic        en,
  input  logic        sync,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  input  logic        clr_ovf,
  output logic [7:0]  drop_cnt,
  output logic [3:0]  slot
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [NCH-1:0] CNT_ONE   = NCH'(1);
  localparam logic [3:0]     SLOT_IDLE = 4'(NCH);
  localparam logic [AW:0]    DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
  localparam logic [AW:0]    CNT1_FIFO = (AW+1)'(1);

  logic [NCH-1:0] cnt_reg, cnt_next;
  logic [7:0]     frame_reg, frame_next;
  logic [3:0]     slot_reg, slot_next;

  logic [15:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]    count_reg, count_next;
  logic [15:0]    out_data_reg, head_next;
  logic           overflow_reg;
  logic [7:0]     drop_cnt_reg;

  logic           push_req, push_acc, pop, full, drop;
  logic [15:0]    push_word;

  // Slot and frame counters; sync overrides the increment.
  always_comb begin
    cnt_next   = cnt_reg + CNT_ONE;
    frame_next = frame_reg;
    if (cnt_reg == '1)
      frame_next = frame_reg + 8'd1;
    if (sync) begin
      cnt_next   = '0;
      frame_next = '0;
    end
  end

  // Trailing-ones decode of the next count: bit gi is set when the low gi+1
  // bits are all ones. These prefix flags are monotone, so their sum is the
  // trailing-ones count. Decoding cnt_next keeps slot aligned with cnt_reg.
  logic [NCH-1:0] prefix_ones;
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_prefix
      assign prefix_ones[gi] = &cnt_next[gi:0];
    end
  endgenerate

  always_comb begin
    slot_next = '0;
    for (int i = 0; i < NCH; i++)
      slot_next = slot_next + 4'(prefix_ones[i]);
  end

  // Capture and FIFO control.
  assign push_word = {slot_reg, read_out_Q, read_out_I, frame_reg};
  assign push_req  = en && (slot_reg != SLOT_IDLE) && (|{read_out_Q, read_out_I});
  assign full      = (count_reg == DEPTH_C);
  assign pop       = out_valid && out_ready;
  assign push_acc  = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  always_comb begin
    count_next = count_reg;
    if (push_acc && !pop)
      count_next = count_reg + CNT1_FIFO;
    else if (pop && !push_acc)
      count_next = count_reg - CNT1_FIFO;
  end

  assign rd_ptr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;

  // Registered head: when the next head location is the one being written
  // this edge, bypass the incoming word since the array still holds old data.
  always_comb begin
    head_next = out_data_reg;
    if (count_next != '0) begin
      if (push_acc && (rd_ptr_next == wr_ptr_reg))
        head_next = push_word;
      else
        head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk_master) begin
    if (push_acc)
      mem[wr_ptr_reg] <= push_word;
  end

  always_ff @(posedge clk_master) begin
    if (rst) begin
      cnt_reg      <= '0;
      frame_reg    <= '0;
      slot_reg     <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      out_data_reg <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      cnt_reg      <= cnt_next;
      frame_reg    <= frame_next;
      slot_reg     <= slot_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      out_data_reg <= head_next;
      if (push_acc)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (clr_ovf) begin
        overflow_reg <= 1'b0;
        drop_cnt_reg <= '0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 8'hFF)
          drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  assign out_valid = (count_reg != '0);
  assign out_data  = out_data_reg;
  assign overflow  = overflow_reg;
  assign drop_cnt  = drop_cnt_reg;
  assign slot      = slot_reg;

endmodule

// File: tb/tb_ro_demux.sv
// Directed bench for ro_demux: a vector table for slot decode, capture and
// sync behaviour, then hand-written sequences for frame wrap, sync at a
// mid-frame count, overflow/saturation/clear and full-FIFO throughput.
module tb_ro_demux;

  logic        clk_master = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  read_out_I = '0;
  logic [1:0]  read_out_Q = '0;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        overflow;
  logic        clr_ovf = 1'b0;
  logic [7:0]  drop_cnt;
  logic [3:0]  slot;

  int total = 0;
  int bad   = 0;

  ro_demux #(.FIFO_DEPTH(8), .NCH(10)) dut (
    .clk_master(clk_master),
    .rst(rst),
    .read_out_I(read_out_I),
    .read_out_Q(read_out_Q),
    .en(en),
    .sync(sync),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow),
    .clr_ovf(clr_ovf),
    .drop_cnt(drop_cnt),
    .slot(slot)
  );

  always #5 clk_master = ~clk_master;

  typedef struct {
    logic        rst;
    logic [1:0]  i;
    logic [1:0]  q;
    logic        en;
    logic        rdy;
    logic        sync;
    logic [3:0]  exp_slot;
    logic        exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vq[$];

  task automatic step();
    @(posedge clk_master);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    read_out_I = '0;
    read_out_Q = '0;
    en = 1'b0;
    sync = 1'b0;
    clr_ovf = 1'b0;
  endtask

  logic [3:0]  slot_seq [16] = '{0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,4};
  logic [15:0] fifo_words [8] = '{16'h0100, 16'h1100, 16'h0100, 16'h2100,
                                  16'h0100, 16'h1100, 16'h0100, 16'h3100};
  logic [15:0] heads [10];

  initial begin
    // Reset state
    step();
    step();
    chk("rst_slot", 32'(slot), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;

    // Vector table: checks are of the state before the row's edge
    for (int k = 0; k < 16; k++)
      vq.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, slot_seq[k], 1'b0, 16'h0000});
    vq.push_back('{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000}); // mid reset
    vq.push_back('{1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000}); // cnt0
    vq.push_back('{1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 16'h0100}); // cnt1
    vq.push_back('{1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 16'h1100}); // cnt2
    vq.push_back('{1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 16'h0100}); // cnt3
    vq.push_back('{1'b0, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 16'h2100}); // cnt4
    vq.push_back('{1'b0, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 16'h0100}); // cnt5 en=0
    vq.push_back('{1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 16'h0000}); // cnt6 sync
    vq.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 16'h0800}); // cnt0
    vq.push_back('{1'b0, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 16'h0000}); // cnt1
    vq.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 16'h1300}); // cnt2
    vq.push_back('{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 16'h0000}); // cnt3

    for (int r = 0; r < vq.size(); r++) begin
      rst        = vq[r].rst;
      read_out_I = vq[r].i;
      read_out_Q = vq[r].q;
      en         = vq[r].en;
      out_ready  = vq[r].rdy;
      sync       = vq[r].sync;
      chk($sformatf("vec%0d_slot", r), 32'(slot), 32'(vq[r].exp_slot));
      chk($sformatf("vec%0d_valid", r), 32'(out_valid), 32'(vq[r].exp_valid));
      if (vq[r].exp_valid)
        chk($sformatf("vec%0d_data", r), 32'(out_data), 32'(vq[r].exp_data));
      $display("vec %0d: slot=%0d valid=%0b data=%04h", r, slot, out_valid, out_data);
      step();
    end
    zero_inputs();
    rst = 1'b0;

    // Frame wrap: nothing pushed in the idle slot, frame=1 afterwards
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 1023; k++) step();
    chk("idle_slot", 32'(slot), 32'd10);
    en = 1'b1; read_out_Q = 2'b11;
    step();
    chk("idle_nopush", 32'(out_valid), 32'd0);
    chk("wrap_slot", 32'(slot), 32'd0);
    step();
    chk("wrap_valid", 32'(out_valid), 32'd1);
    chk("wrap_word", 32'(out_data), 32'h0C01);
    $display("wrap: word=%04h", out_data);
    zero_inputs();
    step(); // cnt=2, word popped
    chk("wrap_pop", 32'(out_valid), 32'd0);

    // Sync at cnt=500 restarts slot and frame
    for (int k = 0; k < 498; k++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_slot", 32'(slot), 32'd0);
    en = 1'b1; read_out_I = 2'b01;
    step();
    chk("sync_word", 32'(out_data), 32'h0100);
    $display("sync: word=%04h", out_data);

    // rst together with sync and events: reset values only
    rst = 1'b1; sync = 1'b1;
    step();
    chk("rstsync_valid", 32'(out_valid), 32'd0);
    chk("rstsync_slot", 32'(slot), 32'd0);
    chk("rstsync_data", 32'(out_data), 32'd0);
    rst = 1'b0; zero_inputs();

    // Overflow: fill with out_ready=0, then drops counted
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0; en = 1'b1; read_out_I = 2'b01;
    for (int k = 0; k < 8; k++) step();
    chk("full_ovf", 32'(overflow), 32'd0);
    chk("full_head", 32'(out_data), 32'h0100);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("drop%0d_ovf", k), 32'(overflow), 32'd1);
      chk($sformatf("drop%0d_cnt", k), 32'(drop_cnt), 32'(k));
      $display("drop: ovf=%0b cnt=%0d", overflow, drop_cnt);
    end
    for (int k = 0; k < 260; k++) step();
    chk("sat_cnt", 32'(drop_cnt), 32'd255);
    chk("sat_head", 32'(out_data), 32'h0100);
    clr_ovf = 1'b1; // a drop also happens on this edge; clear wins
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_cnt", 32'(drop_cnt), 32'd0);

    // Full FIFO with pops and pushes on every edge
    for (int k = 1; k < 8; k++) heads[k] = fifo_words[k];
    heads[8] = 16'h0100;
    heads[9] = 16'h1100;
    out_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("thru%0d_head", k), 32'(out_data), 32'(heads[k]));
      $display("thru %0d: head=%04h drop=%0d", k, out_data, drop_cnt);
    end
    chk("thru_drop", 32'(drop_cnt), 32'd0);
    chk("thru_ovf", 32'(overflow), 32'd0);
    en = 1'b0;
    begin
      int n;
      n = 0;
      while (out_valid && n < 20) begin
        step();
        n++;
      end
      chk("drain_count", 32'(n), 32'd8);
      $display("drain: popped=%0d", n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ro_demux.md
RO_DEMUX -- requirements
Module: ro_demux

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO depth in words; power of 2, range 2..32.
REQ-002 Parameter NCH, default 10, number of time-multiplexed channels sharing the readout lines; fixed at 10 for the 10-bit slot counter.
REQ-003 clk_master  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 read_out_I  input  2  shared I readout line; [0]=event, [1]=polarity-gated event.
REQ-006 read_out_Q  input  2  shared Q readout line; same bit meaning as read_out_I.
REQ-007 en  input  1  capture enable; when low, no words are pushed, but the slot and frame counters keep running.
REQ-008 sync  input  1  realigns the slot counter to the transmit-side gray tree after reset.
REQ-009 out_data  output  16  FIFO head word: [15:12] channel, [11:8] {Q[1],Q[0],I[1],I[0]}, [7:0] frame number.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  consumer accepts out_data on a cycle where out_valid and out_ready are both high.
REQ-012 overflow  output  1  sticky flag set when a word is dropped.
REQ-013 clr_ovf  input  1  clears overflow and drop_cnt.
REQ-014 drop_cnt  output  8  count of dropped words; saturates at 255.
REQ-015 slot  output  4  channel decoded for the current cycle; 10 = idle.

Function
REQ-016 A 10-bit binary slot counter cnt shall increment by 1 every cycle and wrap from 1023 to 0.
REQ-017 The current channel shall equal the number of trailing ones of cnt (0..9), so channel k owns one slot every 2^(k+1) cycles; cnt=1023 is the idle slot (slot=10).
REQ-018 An 8-bit frame counter shall increment on every cnt wrap from 1023 to 0 and wrap from 255 to 0.
REQ-019 When sync=1, the next values shall be cnt=0 and frame=0, overriding the increment.
REQ-020 On each cycle where en=1, the slot is not idle, and any of the four readout bits is 1, the block shall form {slot, Q[1],Q[0],I[1],I[0], frame} from that same cycle's cnt, frame and inputs, and push it.
REQ-021 All-zero readout bits, the idle slot, or en=0 shall push nothing.
REQ-022 Push latency: a word pushed into an empty FIFO at edge N shall appear with out_valid=1 and out_data valid after edge N.
REQ-023 out_data shall be held stable while out_valid=1 and out_ready=0.
REQ-024 Pop occurs on an edge where out_valid=1 and out_ready=1; the FIFO shall be first-in first-out with no reordering.
REQ-025 When the FIFO is full and a pop and a push occur on the same edge, both shall be accepted and occupancy stays FIFO_DEPTH.
REQ-026 When the FIFO is empty and a push occurs, out_valid is 0 that cycle, so no pop can happen; the push shall be accepted.
REQ-027 A push while full with no pop shall drop the new word, set overflow=1, and increment drop_cnt, saturating at 255.
REQ-028 When clr_ovf=1, overflow and drop_cnt shall be 0 next cycle; if a drop occurs in the same cycle, clr_ovf shall win.
REQ-029 slot shall be a registered view of the decode applied to the current cnt, with no additional latency beyond cnt.

Reset
REQ-030 While rst=1 at an edge, the block shall set cnt=0, frame=0, FIFO empty, out_valid=0, out_data=0, overflow=0, drop_cnt=0, slot=0.
REQ-031 rst shall take priority over sync, en, clr_ovf and pop.
REQ-032 Reset mid-operation shall discard all FIFO contents; captures shall resume on the first cycle after rst deasserts.

Verification
REQ-033 Rst for 2 cycles, then run 16 cycles: slot sequence 0,1,0,2,0,1,0,3,0,1,0,2,0,1,0,4; out_valid stays 0 with all inputs 0.
REQ-034 Hold read_out_I=2'b01, en=1, out_ready=1, and check words in cycles 0..3: 16'h0100 (cnt=0), 16'h1100 (cnt=1), 16'h0100 (cnt=2), 16'h2100 (cnt=3), each valid one cycle after capture.
REQ-035 Drive read_out_Q=2'b11 only when cnt=1023 -> no word pushed; after the wrap, frame=1, so the next word pushed with read_out_Q=2'b11 at cnt=0 is 16'h0C01.
REQ-036 Set out_ready=0 with events every cycle: after FIFO_DEPTH pushes, overflow=1 and drop_cnt counts 1,2,...; the FIFO head equals the first word; pulse clr_ovf -> overflow=0 and drop_cnt=0.
REQ-037 Hold a full FIFO with out_ready=1 and continuous events: occupancy stays FIFO_DEPTH and drop_cnt does not change.
REQ-038 Assert sync at cnt=500 -> next cnt=0 and slot=0; assert rst and sync together -> reset values only.
